// File: rtl/fade_pack.sv
// Shared constants and types for the fader-output combiner: path/channel counts,
// accumulator width, complex sample/coefficient payloads and the combiner FSM states.
package fade_pack;

    localparam int unsigned M      = 8;
    localparam int unsigned N      = 32;
    localparam int unsigned W_IN   = 16;
    localparam int unsigned SHIFT  = 2;
    localparam int unsigned CHAN_W = 5;
    localparam int unsigned CNT_W  = $clog2(M);
    localparam int unsigned ACC_W  = W_IN + $clog2(M);

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx16_t;

    typedef struct packed {
        logic signed [ACC_W-1:0] re;
        logic signed [ACC_W-1:0] im;
    } cplx_acc_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } comb_state_t;

endpackage

// File: rtl/fade_round_sat.sv
// Combinational round-half-up, arithmetic right shift and 16-bit saturation of one
// accumulated path sum.
module fade_round_sat
    import fade_pack::*;
(
    input  logic signed [ACC_W-1:0] val_i,
    output logic signed [15:0]      res_o
);

    // One guard bit keeps the rounding add from wrapping at the positive limit.
    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] RND     = EXT_W'((2 ** SHIFT) / 2);
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(32767);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-32768);

    logic signed [EXT_W-1:0] rounded_c;
    logic signed [EXT_W-1:0] shifted_c;

    always_comb begin
        rounded_c = EXT_W'(val_i) + RND;
        shifted_c = rounded_c >>> SHIFT;
        if (shifted_c > SAT_MAX) begin
            res_o = 16'sh7fff;
        end else if (shifted_c < SAT_MIN) begin
            res_o = 16'sh8000;
        end else begin
            res_o = shifted_c[15:0];
        end
    end

endmodule

// File: rtl/fade_combiner.sv
// Sums M complex path samples per channel into one rounded/saturated 16-bit coefficient,
// strobes it out, stores it in an N-entry bank with registered readback, flags misordering.
module fade_combiner
    import fade_pack::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dv_in,
    input  logic [CHAN_W-1:0]        chan_in,
    input  logic signed [W_IN-1:0]   zc_real_in,
    input  logic signed [W_IN-1:0]   zc_imag_in,
    output logic                     coef_valid,
    output logic [CHAN_W-1:0]        coef_chan,
    output logic signed [15:0]       coef_real,
    output logic signed [15:0]       coef_imag,
    output logic                     frame_done,
    output logic                     err_seq,
    input  logic [CHAN_W-1:0]        rd_chan,
    output logic signed [15:0]       rd_real,
    output logic signed [15:0]       rd_imag,
    output logic                     rd_valid
);

    comb_state_t       state_q, state_d;
    cplx_acc_t         acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CHAN_W-1:0] cur_chan_q, cur_chan_d;
    cplx16_t           coef_q, coef_d;
    logic [CHAN_W-1:0] coef_chan_q, coef_chan_d;
    logic              coef_valid_q, coef_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;
    logic              wr_en_c;

    cplx_acc_t         samp_c;
    cplx_acc_t         sum_c;
    cplx16_t           rnd_c;

    cplx16_t           bank_q [N];
    logic [N-1:0]      bank_vld_q;
    cplx16_t           rd_q;
    logic              rd_valid_q;

    assign samp_c.re = ACC_W'(zc_real_in);
    assign samp_c.im = ACC_W'(zc_imag_in);
    assign sum_c.re  = acc_q.re + samp_c.re;
    assign sum_c.im  = acc_q.im + samp_c.im;

    fade_round_sat u_rs_re (
        .val_i (sum_c.re),
        .res_o (rnd_c.re)
    );

    fade_round_sat u_rs_im (
        .val_i (sum_c.im),
        .res_o (rnd_c.im)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        cur_chan_d   = cur_chan_q;
        coef_d       = coef_q;
        coef_chan_d  = coef_chan_q;
        coef_valid_d = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        wr_en_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dv_in) begin
                    acc_d      = samp_c;
                    cnt_d      = CNT_W'(1);
                    cur_chan_d = chan_in;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (dv_in) begin
                    if (chan_in != cur_chan_q) begin
                        // Abandon the partial channel and restart on the interloper.
                        err_d      = 1'b1;
                        acc_d      = samp_c;
                        cnt_d      = CNT_W'(1);
                        cur_chan_d = chan_in;
                    end else if (cnt_q == CNT_W'(M - 1)) begin
                        coef_valid_d = 1'b1;
                        coef_d       = rnd_c;
                        coef_chan_d  = cur_chan_q;
                        frame_done_d = (cur_chan_q == '0);
                        wr_en_c      = (32'(cur_chan_q) < N);
                        state_d      = IDLE;
                    end else begin
                        acc_d = sum_c;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            cur_chan_q   <= '0;
            coef_q       <= '0;
            coef_chan_q  <= '0;
            coef_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            bank_vld_q   <= '0;
            rd_q         <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            cur_chan_q   <= cur_chan_d;
            coef_q       <= coef_d;
            coef_chan_q  <= coef_chan_d;
            coef_valid_q <= coef_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            if (wr_en_c) begin
                bank_vld_q[cur_chan_q] <= 1'b1;
            end
            rd_q       <= bank_q[rd_chan];
            rd_valid_q <= bank_vld_q[rd_chan];
        end
    end

    // Bank data is not reset; a same-edge read of the written entry sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            bank_q[cur_chan_q] <= rnd_c;
        end
    end

    assign coef_valid = coef_valid_q;
    assign coef_chan  = coef_chan_q;
    assign coef_real  = coef_q.re;
    assign coef_imag  = coef_q.im;
    assign frame_done = frame_done_q;
    assign err_seq    = err_q;
    assign rd_real    = rd_q.re;
    assign rd_imag    = rd_q.im;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_fade_combiner.sv
// Directed and randomized bench for fade_combiner against a per-channel sum/round/saturate
// reference model with a shadow coefficient bank.
module tb_fade_combiner;
    import fade_pack::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               dv_in;
    logic [4:0]         chan_in;
    logic signed [15:0] zc_real_in;
    logic signed [15:0] zc_imag_in;
    logic               coef_valid;
    logic [4:0]         coef_chan;
    logic signed [15:0] coef_real;
    logic signed [15:0] coef_imag;
    logic               frame_done;
    logic               err_seq;
    logic [4:0]         rd_chan;
    logic signed [15:0] rd_real;
    logic signed [15:0] rd_imag;
    logic               rd_valid;

    fade_combiner dut (
        .clk        (clk),
        .reset      (reset),
        .dv_in      (dv_in),
        .chan_in    (chan_in),
        .zc_real_in (zc_real_in),
        .zc_imag_in (zc_imag_in),
        .coef_valid (coef_valid),
        .coef_chan  (coef_chan),
        .coef_real  (coef_real),
        .coef_imag  (coef_imag),
        .frame_done (frame_done),
        .err_seq    (err_seq),
        .rd_chan    (rd_chan),
        .rd_real    (rd_real),
        .rd_imag    (rd_imag),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: the open channel's running sums and sample count.
    bit     m_active;
    int     m_chan;
    int     m_cnt;
    longint m_sre;
    longint m_sim;
    bit     m_err;
    bit     exp_valid;
    bit     exp_frame;
    int     last_chan;
    int     last_re;
    int     last_im;
    bit     mb_valid [N];
    int     mb_re [N];
    int     mb_im [N];
    bit     exp_rd_valid;
    int     exp_rd_re;
    int     exp_rd_im;
    int     fd_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    function automatic int ref_coef(input longint s_in);
        longint s;
        s = s_in + longint'((2 ** SHIFT) / 2);
        s = s >>> SHIFT;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    function automatic void model_sample(input int ch, input int re, input int im);
        if (m_active && ch != m_chan) begin
            m_err    = 1'b1;
            m_active = 1'b0;
        end
        if (!m_active) begin
            m_active = 1'b1;
            m_chan   = ch;
            m_cnt    = 0;
            m_sre    = 0;
            m_sim    = 0;
        end
        m_sre += longint'(re);
        m_sim += longint'(im);
        m_cnt++;
        if (m_cnt == int'(M)) begin
            m_active  = 1'b0;
            exp_valid = 1'b1;
            exp_frame = (m_chan == 0);
            last_chan = m_chan;
            last_re   = ref_coef(m_sre);
            last_im   = ref_coef(m_sim);
            if (m_chan < int'(N)) begin
                mb_valid[m_chan] = 1'b1;
                mb_re[m_chan]    = last_re;
                mb_im[m_chan]    = last_im;
            end
        end
    endfunction

    task automatic check_outputs();
        chk("coef_valid", 32'(coef_valid), 32'(exp_valid));
        chk("frame_done", 32'(frame_done), 32'(exp_frame));
        chk("err_seq", 32'(err_seq), 32'(m_err));
        chk("coef_chan", 32'(coef_chan), 32'(last_chan));
        chk("coef_real", 32'(coef_real), 32'(last_re));
        chk("coef_imag", 32'(coef_imag), 32'(last_im));
        chk("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
        if (exp_rd_valid) begin
            chk("rd_real", 32'(rd_real), 32'(exp_rd_re));
            chk("rd_imag", 32'(rd_imag), 32'(exp_rd_im));
        end
        if (frame_done === 1'b1) fd_count++;
    endtask

    // One clock: check what the previous edge produced, then drive this cycle's inputs.
    task automatic step(input bit dv, input int ch, input int re, input int im, input int rch);
        @(negedge clk);
        check_outputs();
        dv_in        = dv;
        chan_in      = 5'(ch);
        zc_real_in   = 16'(re);
        zc_imag_in   = 16'(im);
        rd_chan      = 5'(rch);
        exp_rd_valid = mb_valid[rch];
        exp_rd_re    = mb_re[rch];
        exp_rd_im    = mb_im[rch];
        exp_valid    = 1'b0;
        exp_frame    = 1'b0;
        if (dv) model_sample(ch, re, im);
    endtask

    task automatic idle(input int rch);
        step(1'b0, 0, 0, 0, rch);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        dv_in = 1'b0;
        #1;
        chk("rst_coef_valid", 32'(coef_valid), 32'd0);
        chk("rst_coef_chan", 32'(coef_chan), 32'd0);
        chk("rst_coef_real", 32'(coef_real), 32'd0);
        chk("rst_coef_imag", 32'(coef_imag), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err_seq", 32'(err_seq), 32'd0);
        chk("rst_rd_real", 32'(rd_real), 32'd0);
        chk("rst_rd_imag", 32'(rd_imag), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        m_active     = 1'b0;
        m_err        = 1'b0;
        exp_valid    = 1'b0;
        exp_frame    = 1'b0;
        last_chan    = 0;
        last_re      = 0;
        last_im      = 0;
        exp_rd_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) mb_valid[i] = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int ch;
        int n;
        int fd0;
        reset      = 1'b0;
        dv_in      = 1'b0;
        chan_in    = '0;
        zc_real_in = '0;
        zc_imag_in = '0;
        rd_chan    = '0;
        for (int i = 0; i < int'(N); i++) begin
            mb_valid[i] = 1'b0;
            mb_re[i]    = 0;
            mb_im[i]    = 0;
        end
        do_reset(3);

        // Single channel 31, contiguous, then readback.
        for (int k = 0; k < int'(M); k++) step(1'b1, 31, 1000, -1000, 0);
        idle(31);
        chk("t1_coef_real", 32'(coef_real), 32'd2000);
        chk("t1_coef_imag", 32'(coef_imag), 32'(-2000));
        chk("t1_coef_chan", 32'(coef_chan), 32'd31);
        idle(31);
        chk("t1_rd_real", 32'(rd_real), 32'd2000);
        chk("t1_rd_valid", 32'(rd_valid), 32'd1);

        // Saturation at both rails.
        for (int k = 0; k < int'(M); k++) step(1'b1, 7, 32767, -32768, 7);
        idle(7);
        chk("t2_sat_real", 32'(coef_real), 32'd32767);
        chk("t2_sat_imag", 32'(coef_imag), 32'(-32768));
        idle(7);

        // Full descending frame, back-to-back.
        fd0 = fd_count;
        for (int c = 31; c >= 0; c--) begin
            for (int k = 0; k < int'(M); k++) step(1'b1, c, c * 100, 0, c);
        end
        idle(0);
        chk("t3_last_real", 32'(coef_real), 32'd0);
        idle(16);
        chk("t3_frame_done_count", 32'(fd_count - fd0), 32'd1);
        chk("t3_err_seq", 32'(err_seq), 32'd0);

        // Abandoned partial channel.
        do_reset(1);
        for (int k = 0; k < 3; k++) step(1'b1, 5, 111, 222, 5);
        for (int k = 0; k < int'(M); k++) step(1'b1, 4, 50, -50, 5);
        idle(5);
        chk("t4_coef_chan", 32'(coef_chan), 32'd4);
        idle(4);
        chk("t4_rd5_valid", 32'(rd_valid), 32'd0);
        idle(4);
        chk("t4_rd4_valid", 32'(rd_valid), 32'd1);
        chk("t4_err_sticky", 32'(err_seq), 32'd1);

        // Gapped delivery, dv every third cycle.
        for (int k = 0; k < int'(M); k++) begin
            step(1'b1, 31, 1000, -1000, 0);
            idle(0);
            idle(0);
        end
        chk("t5_coef_real", 32'(coef_real), 32'd2000);
        chk("t5_coef_imag", 32'(coef_imag), 32'(-2000));

        // Reset in mid-accumulation.
        for (int k = 0; k < 4; k++) step(1'b1, 9, 7000, 300, 0);
        do_reset(1);
        for (int i = 0; i < 4; i++) idle(i * 9);
        for (int k = 0; k < int'(M); k++) step(1'b1, 9, 4, 0, 9);
        idle(9);
        chk("t6_coef_real", 32'(coef_real), 32'd8);
        chk("t6_coef_imag", 32'(coef_imag), 32'd0);
        chk("t6_coef_chan", 32'(coef_chan), 32'd9);
        idle(9);

        // Randomized channels, gaps, early abandons and readback.
        for (int t = 0; t < 60; t++) begin
            ch = int'($urandom_range(31));
            n  = ($urandom_range(4) == 0) ? int'($urandom_range(M - 1, 1)) : int'(M);
            for (int k = 0; k < n; k++) begin
                while ($urandom_range(3) == 0) idle(int'($urandom_range(31)));
                if ($urandom_range(5) == 0) begin
                    step(1'b1, ch, ($urandom_range(1) == 0) ? 32767 : -32768,
                         ($urandom_range(1) == 0) ? 32767 : -32768, int'($urandom_range(31)));
                end else begin
                    step(1'b1, ch, int'($urandom_range(65535)) - 32768,
                         int'($urandom_range(65535)) - 32768, int'($urandom_range(31)));
                end
            end
        end
        for (int i = 0; i < 4; i++) idle(int'($urandom_range(31)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fade_combiner.md
Name: fade_combiner

Overview:
Receiving end of the fader output stream: consumes the dv_out/chan_out/Zc_real/Zc_imag sample stream, M path samples per channel.
Sums the M complex path samples of each channel, then rounds, scales and saturates the sum into one 16-bit complex fading coefficient per channel.
Presents each coefficient as a one-cycle strobe and also stores it in an N-entry coefficient bank for random readback by the channel-apply datapath.
Checks stream ordering and flags sequencing errors.

Parameters:
M, 8, paths per channel; power of two, ≥ 2
N, 32, channels per frame
W_IN, 16, input sample width, signed
SHIFT, 2, right shift applied to the path sum; 0 ≤ SHIFT ≤ log2(M)+W_IN-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
dv_in  in  1  path sample valid
chan_in  in  5  channel of the current sample
zc_real_in  in  16  signed real part of path sample
zc_imag_in  in  16  signed imag part of path sample
coef_valid  out  1  one-cycle strobe, coefficient ready
coef_chan  out  5  channel of the coefficient
coef_real  out  16  signed real coefficient
coef_imag  out  16  signed imag coefficient
frame_done  out  1  one-cycle strobe, channel 0 coefficient completed
err_seq  out  1  sticky: partial channel abandoned
rd_chan  in  5  bank read address
rd_real  out  16  bank read data, real
rd_imag  out  16  bank read data, imag
rd_valid  out  1  entry at rd_chan written since reset

Behaviour:
- Reset (reset=0, async): coef_valid=0, coef_chan=0, coef_real=0, coef_imag=0, frame_done=0, err_seq=0, rd_real=0, rd_imag=0, rd_valid=0. State=IDLE. All bank valid bits clear. Bank data is not reset.
- Accumulators: real and imag, signed, W_IN+log2(M) = 19 bits. Path counter: log2(M) bits. cur_chan register: 5 bits.
- IDLE, dv_in=1: acc <= sample (sign-extended), cnt <= 1, cur_chan <= chan_in, go to ACCUM.
- ACCUM, dv_in=0: hold all state. Gaps of any length are legal.
- ACCUM, dv_in=1, chan_in==cur_chan, cnt<M-1: acc += sample, cnt++.
- ACCUM, dv_in=1, chan_in==cur_chan, cnt==M-1: final sum = acc+sample. At that clock edge, register the result to the outputs, write the bank, go to IDLE.
- A new sample on the very next cycle is accepted by IDLE. Back-to-back channels run with no bubble.
- ACCUM, dv_in=1, chan_in!=cur_chan: set err_seq. Discard the partial sum. Restart with this sample (acc<=sample, cnt<=1, cur_chan<=chan_in). Stay in ACCUM.
- Output computation: r = (sum + 2^(SHIFT-1)) >>> SHIFT; when SHIFT=0 there is no rounding add. Saturate r to [-32768, 32767].
- Latency: coef_valid is high for exactly one cycle, in the cycle after the M-th accepted sample.
- coef_chan/real/imag hold their value until the next coef_valid.
- frame_done pulses in the same cycle as coef_valid when coef_chan==0.
- Bank: N×32 bits. The write occurs at the same edge that asserts coef_valid and sets valid[chan].
- Bank read is registered with 1-cycle latency: rd_* reflect rd_chan from the previous cycle.
- Read and write of the same address in the same cycle returns the OLD data; the new data is visible on the following read.
- err_seq clears only on reset.
- Reset asserted mid-accumulation discards the partial sum. No coef_valid is produced for that channel.
- chan_in ≥ N: treated as an ordinary channel for accumulation, but the bank write is suppressed.

Decomposition:
- Shared package fade_pack:
  - constants M, N, SHIFT, ACC_W = W_IN+$clog2(M)
  - typedef cplx16_t (struct: signed [15:0] re, im)
  - typedef cplx_acc_t
  - enum comb_state_t {IDLE, ACCUM}
- One sub-module: fade_round_sat. Combinational round, shift and saturate of one ACC_W-bit value to 16 bits; instantiated for real and imag.

Test Plan:
- 8 samples chan=31, real=1000, imag=-1000, contiguous -> one coef_valid a cycle after the 8th sample: coef_chan=31, real=2000, imag=-2000. rd_chan=31 then gives the same values with rd_valid=1.
- 8 samples chan=7, real=32767, imag=-32768 -> real saturates to 32767, imag saturates to -32768.
- Full frame: 256 contiguous samples, chan 31..0 descending, 8 each, real=chan*100, imag=0 -> 32 coef_valid strobes at 8-cycle spacing with real=chan*200. frame_done exactly once, with chan 0. err_seq=0.
- 3 samples chan=5, then 8 samples chan=4 -> err_seq=1 and stays 1. No coef for chan 5. chan 4 coef produced. Bank entry 5 has rd_valid=0.
- Same 8 samples as the first test, but with dv_in pulsed every 3rd cycle -> identical coefficient, 1 cycle after the last sample.
- reset=0 for 1 cycle after the 4th sample of chan 9, then 8 fresh samples of real=4 -> only one coef_valid, with real=8, imag=0. Bank valid bits are clear before it.
